argmax_tree_fp: RTL and testbench
=================================

// Module: argmax_tree_fp
// PURPOSE
// - Pipelined max/argmax reduction over CHANNELS IEEE-754 single-precision Q-values.
// - Returns the maximum value and the index of the channel that produced it.
// - Used for greedy action selection, max_a Q(s',a), in the Q-update datapath.
// - Supersedes the single-level pairwise max stage:
//   - full binary reduction tree;
//   - index tracking;
//   - valid/ready backpressure;
//   - no tri-stated outputs.
// PARAMETERS
// - CHANNELS    ACTIONS             number of input values, >=1
// - DATA_WIDTH  32                  width of each value (IEEE-754 single)
// - IDX_WIDTH   max(1,$clog2(CH))   width of the winning index
// - LATENCY     max(1,$clog2(CH))   derived, localparam: number of register stages
// PORTS
// - clk        in   1                  clock, all logic on rising edge
// - rst        in   1                  synchronous, active-high reset
// - in_data    in   DATA_WIDTH*CH      channel k at bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
// - valid_in   in   1                  in_data is valid this cycle
// - ready_in   out  1                  block accepts in_data this cycle
// - out_max    out  DATA_WIDTH         maximum value
// - out_idx    out  IDX_WIDTH          channel index of out_max
// - valid_out  out  1                  out_max/out_idx valid
// - ready_out  in   1                  downstream accepts the result
// BEHAVIOUR
// - Advance enable: adv = ~valid_out | ready_out; ready_in = adv (combinational).
// - Pipeline handling:
//   - When adv=1, every stage register, including its valid bit, loads from the previous stage.
//   - When adv=0, the whole pipeline holds; there are no bubbles-collapse.
// - Transfer rule: an input is accepted iff valid_in & ready_in.
// - Latency is exactly LATENCY cycles with ready_out held 1.
// - Throughput is 1 result per cycle.
// - Stage s reduces N_s entries to ceil(N_s/2):
//   - pair (2j, 2j+1) goes to the comparator;
//   - an odd last entry passes through registered, keeping its index.
// - CHANNELS=1: one register stage; out_max=in_data, out_idx=0.
// - Comparison uses a total-order key:
//   - key = sign ? ~x : x ^ 0x8000_0000;
//   - compare keys as unsigned values;
//   - consequently -0.0 < +0.0;
//   - NaNs order by bit pattern; upstream guarantees no NaN.
// - Tie (equal keys): the lower index wins; the a-side is always the lower index.
// - Index widths:
//   - indices are IDX_WIDTH bits at every stage;
//   - stage-0 index k is the constant k.
// - Data/idx registers:
//   - load only when adv=1, regardless of the valid bit;
//   - outputs hold their last value while valid_out=0 or while stalled.
// - Reset:
//   - all valid bits -> 0;
//   - out_max -> 0, out_idx -> 0;
//   - internal data/idx registers -> 0.
// - Reset mid-operation discards in-flight results; ready_in=1 in the cycle after rst drops.
// - Simultaneous ready_out=1 with a new accept: the output is replaced in the same edge, with no gap.
// STRUCTURE
// - Package q_pkg holds:
//   - DATA_WIDTH and ACTIONS;
//   - function fp_key(x) for the total-order transform;
//   - function clog2_min1(n).
// - Sub-module max_2_idx_fp:
//   - inputs: a, a_idx, b, b_idx, en, rst, clk;
//   - registered outputs: max, idx;
//   - a wins on tie.
// - Top level: a generate loop per stage over pairs, plus a pass-through for an odd entry.
// - The stage valid shift register lives in the top level.
// TESTING
// - CH=4, in={ch0:1.0 0x3F800000, ch1:2.0 0x40000000, ch2:-3.0 0xC0400000, ch3:0.5 0x3F000000},
//   ready_out=1 -> after 2 cycles: out_max=0x40000000, out_idx=1, valid_out=1.
// - CH=4, all channels 0x3F800000 -> out_idx=0 (tie, lowest index).
// - CH=4, {-1.0 0xBF800000, -0.5 0xBF000000, -2.0, -4.0} -> out_max=0xBF000000, idx=1.
//   Also in {-0.0, +0.0, -1, -1}: idx=1.
// - CH=5, max at ch4 (ch4=8.0 0x41000000, others 1.0) -> latency 3, out_idx=4 (odd pass-through).
// - Stream 4 back-to-back vectors, ready_out=0 for 3 cycles mid-stream:
//   - ready_in=0 while stalled;
//   - no result is lost or duplicated; results arrive in order.
// - Assert rst for 1 cycle with 2 vectors in flight -> valid_out=0, out_max=0, out_idx=0 next cycle;
//   no stale result afterwards.

Source files
------------

// File: rtl/q_pkg.sv
// Shared widths and helpers for the Q-update datapath.
package q_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ACTIONS    = 4;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Live entry count after s pairwise halvings of n entries.
  function automatic int stage_width(input int n, input int s);
    int w;
    w = n;
    for (int i = 0; i < s; i++) w = (w + 1) / 2;
    return w;
  endfunction

  // Maps IEEE-754 bit patterns onto an order that compares as plain unsigned.
  function automatic logic [DATA_WIDTH-1:0] fp_key(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? ~x : (x ^ {1'b1, {(DATA_WIDTH-1){1'b0}}});
  endfunction

endpackage

// File: rtl/max_2_idx_fp.sv
// Registered two-input float max with index tracking; a wins on equal keys.
module max_2_idx_fp #(
  parameter int DATA_WIDTH = q_pkg::DATA_WIDTH,
  parameter int IDX_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [IDX_WIDTH-1:0]  a_idx,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [IDX_WIDTH-1:0]  b_idx,
  output logic [DATA_WIDTH-1:0] max,
  output logic [IDX_WIDTH-1:0]  idx
);
  import q_pkg::*;

  logic a_wins;

  assign a_wins = fp_key(a) >= fp_key(b);

  always_ff @(posedge clk) begin
    if (rst) begin
      max <= '0;
      idx <= '0;
    end else if (en) begin
      max <= a_wins ? a : b;
      idx <= a_wins ? a_idx : b_idx;
    end
  end

endmodule

// File: rtl/argmax_tree_fp.sv
// Pipelined max/argmax reduction tree over CHANNELS single-precision values.
module argmax_tree_fp #(
  parameter int CHANNELS   = q_pkg::ACTIONS,
  parameter int DATA_WIDTH = q_pkg::DATA_WIDTH,
  parameter int IDX_WIDTH  = q_pkg::clog2_min1(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH*CHANNELS-1:0] in_data,
  input  logic                           valid_in,
  output logic                           ready_in,
  output logic [DATA_WIDTH-1:0]          out_max,
  output logic [IDX_WIDTH-1:0]           out_idx,
  output logic                           valid_out,
  input  logic                           ready_out
);
  import q_pkg::*;

  localparam int LATENCY = clog2_min1(CHANNELS);

  logic                  adv;
  logic [LATENCY-1:0]    vld_q;
  logic [LATENCY:0]      vld_chain;
  logic [DATA_WIDTH-1:0] data [0:LATENCY][0:CHANNELS-1];
  logic [IDX_WIDTH-1:0]  idx  [0:LATENCY][0:CHANNELS-1];

  // The whole pipeline moves together or holds together.
  assign adv       = ~valid_out | ready_out;
  assign ready_in  = adv;
  assign vld_chain = {vld_q, valid_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= vld_chain[LATENCY-1:0];
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_in
    assign data[0][k] = in_data[DATA_WIDTH*k +: DATA_WIDTH];
    assign idx[0][k]  = IDX_WIDTH'(k);
  end

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    localparam int N = stage_width(CHANNELS, s);
    localparam int M = stage_width(CHANNELS, s + 1);

    for (genvar j = 0; j < N / 2; j++) begin : g_pair
      max_2_idx_fp #(
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
      ) u_cmp (
        .clk  (clk),
        .rst  (rst),
        .en   (adv),
        .a    (data[s][2*j]),
        .a_idx(idx[s][2*j]),
        .b    (data[s][2*j+1]),
        .b_idx(idx[s][2*j+1]),
        .max  (data[s+1][j]),
        .idx  (idx[s+1][j])
      );
    end

    // An unpaired last entry is delayed one stage so it stays aligned with its vector.
    if (N % 2 == 1) begin : g_odd
      logic [DATA_WIDTH-1:0] pass_data;
      logic [IDX_WIDTH-1:0]  pass_idx;

      always_ff @(posedge clk) begin
        if (rst) begin
          pass_data <= '0;
          pass_idx  <= '0;
        end else if (adv) begin
          pass_data <= data[s][N-1];
          pass_idx  <= idx[s][N-1];
        end
      end

      assign data[s+1][M-1] = pass_data;
      assign idx[s+1][M-1]  = pass_idx;
    end

    for (genvar k = M; k < CHANNELS; k++) begin : g_unused
      assign data[s+1][k] = '0;
      assign idx[s+1][k]  = '0;
    end
  end

  assign out_max   = data[LATENCY][0];
  assign out_idx   = idx[LATENCY][0];
  assign valid_out = vld_q[LATENCY-1];

endmodule

// File: tb/tb_argmax_tree_fp.sv
// Scoreboarded bench for argmax_tree_fp at CHANNELS=4 and CHANNELS=5.
module tb_argmax_tree_fp;

  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] mx;
    int unsigned   idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4*DW-1:0] in4;
  logic            vin4, rin4, vout4, rout4;
  logic [DW-1:0]   max4;
  logic [1:0]      idx4;

  logic [5*DW-1:0] in5;
  logic            vin5, rin5, vout5, rout5;
  logic [DW-1:0]   max5;
  logic [2:0]      idx5;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t q4[$];
  exp_t q5[$];
  bit   stim_done;

  argmax_tree_fp #(.CHANNELS(4), .DATA_WIDTH(DW), .IDX_WIDTH(2)) dut4 (
    .clk(clk), .rst(rst), .in_data(in4), .valid_in(vin4), .ready_in(rin4),
    .out_max(max4), .out_idx(idx4), .valid_out(vout4), .ready_out(rout4)
  );

  argmax_tree_fp #(.CHANNELS(5), .DATA_WIDTH(DW), .IDX_WIDTH(3)) dut5 (
    .clk(clk), .rst(rst), .in_data(in5), .valid_in(vin5), .ready_in(rin5),
    .out_max(max5), .out_idx(idx5), .valid_out(vout5), .ready_out(rout5)
  );

  // Reference ordering straight from float semantics: positive beats negative, +0 beats -0.
  function automatic bit fp_greater(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (a[DW-1] != b[DW-1]) return b[DW-1];
    if (a[DW-1] == 1'b0) return a[DW-2:0] > b[DW-2:0];
    return a[DW-2:0] < b[DW-2:0];
  endfunction

  function automatic exp_t ref_argmax(input logic [5*DW-1:0] flat, input int n);
    exp_t          r;
    logic [DW-1:0] v;
    r.mx  = flat[DW-1:0];
    r.idx = 0;
    for (int k = 1; k < n; k++) begin
      v = flat[DW*k +: DW];
      if (fp_greater(v, r.mx)) begin
        r.mx  = v;
        r.idx = k;
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_fp();
    logic [DW-1:0] r;
    case ($urandom_range(0, 6))
      0:       r = 32'h3F80_0000;
      1:       r = 32'h8000_0000;
      2:       r = 32'h0000_0000;
      3:       r = 32'hBF80_0000;
      default: begin
        r = $urandom;
        if (r[30:23] == 8'hFF) r[30] = 1'b0;
      end
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus4(input logic [4*DW-1:0] v);
    bit taken;
    taken = 1'b0;
    in4   = v;
    vin4  = 1'b1;
    for (int c = 0; c < 100 && !taken; c++) begin
      @(negedge clk);
      taken = rin4 && !rst;
      @(posedge clk);
      #1;
    end
    vin4 = 1'b0;
    if (!taken) checkOutput("dut4 accept timeout", {31'b0, rin4}, 32'd1);
  endtask

  task automatic applyStimulus5(input logic [5*DW-1:0] v);
    bit taken;
    taken = 1'b0;
    in5   = v;
    vin5  = 1'b1;
    for (int c = 0; c < 100 && !taken; c++) begin
      @(negedge clk);
      taken = rin5 && !rst;
      @(posedge clk);
      #1;
    end
    vin5 = 1'b0;
    if (!taken) checkOutput("dut5 accept timeout", {31'b0, rin5}, 32'd1);
  endtask

  task automatic directed4(input string name, input logic [4*DW-1:0] v,
                           input logic [DW-1:0] exp_max, input logic [DW-1:0] exp_idx);
    applyStimulus4(v);
    @(negedge clk);
    checkOutput({name, " early valid"}, {31'b0, vout4}, 32'd0);
    @(negedge clk);
    checkOutput({name, " valid_out"}, {31'b0, vout4}, 32'd1);
    checkOutput({name, " max"}, max4, exp_max);
    checkOutput({name, " idx"}, {30'b0, idx4}, exp_idx);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 60 && (q4.size() != 0 || q5.size() != 0); c++) @(negedge clk);
    checkOutput("dut4 results outstanding", 32'(q4.size()), 32'd0);
    checkOutput("dut5 results outstanding", 32'(q5.size()), 32'd0);
  endtask

  // Monitor: retire the oldest expectation on each output transfer, then log new accepts.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q4.delete();
      q5.delete();
    end else begin
      if (vout4 && rout4) begin
        if (q4.size() == 0) checkOutput("dut4 spurious result", {31'b0, vout4}, 32'd0);
        else begin
          e = q4.pop_front();
          checkOutput("dut4 sb max", max4, e.mx);
          checkOutput("dut4 sb idx", {30'b0, idx4}, DW'(e.idx));
        end
      end
      if (vout5 && rout5) begin
        if (q5.size() == 0) checkOutput("dut5 spurious result", {31'b0, vout5}, 32'd0);
        else begin
          e = q5.pop_front();
          checkOutput("dut5 sb max", max5, e.mx);
          checkOutput("dut5 sb idx", {29'b0, idx5}, DW'(e.idx));
        end
      end
      if (vin4 && rin4) q4.push_back(ref_argmax({{DW{1'b0}}, in4}, 4));
      if (vin5 && rin5) q5.push_back(ref_argmax(in5, 5));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; vin4 = 1'b0; vin5 = 1'b0; in4 = '0; in5 = '0;
    rout4 = 1'b1; rout5 = 1'b1; stim_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset valid_out", {31'b0, vout4}, 32'd0);
    checkOutput("reset out_max", max4, 32'd0);
    checkOutput("reset out_idx", {30'b0, idx4}, 32'd0);
    checkOutput("reset dut5 valid_out", {31'b0, vout5}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_in after reset", {31'b0, rin4}, 32'd1);
    @(posedge clk);
    #1;

    directed4("mixed", {32'h3F00_0000, 32'hC040_0000, 32'h4000_0000, 32'h3F80_0000},
              32'h4000_0000, 32'd1);
    directed4("all equal", {4{32'h3F80_0000}}, 32'h3F80_0000, 32'd0);
    directed4("negatives", {32'hC080_0000, 32'hC000_0000, 32'hBF00_0000, 32'hBF80_0000},
              32'hBF00_0000, 32'd1);
    directed4("signed zero", {32'hBF80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h8000_0000},
              32'h0000_0000, 32'd1);

    applyStimulus5({32'h4100_0000, {4{32'h3F80_0000}}});
    repeat (2) begin
      @(negedge clk);
      checkOutput("ch5 early valid", {31'b0, vout5}, 32'd0);
    end
    @(negedge clk);
    checkOutput("ch5 valid_out", {31'b0, vout5}, 32'd1);
    checkOutput("ch5 max", max5, 32'h4100_0000);
    checkOutput("ch5 idx", {29'b0, idx5}, 32'd4);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back stream with a three-cycle downstream stall once results appear.
    fork
      begin
        applyStimulus4({32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000});
        applyStimulus4({32'h4080_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000});
        applyStimulus4({32'h4040_0000, 32'h4080_0000, 32'h3F80_0000, 32'h4000_0000});
        applyStimulus4({32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h3F80_0000});
      end
      begin
        for (int c = 0; c < 20 && !vout4; c++) begin
          @(posedge clk);
          #1;
        end
        checkOutput("stall entry valid_out", {31'b0, vout4}, 32'd1);
        rout4 = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("stall ready_in", {31'b0, rin4}, 32'd0);
          @(posedge clk);
          #1;
        end
        rout4 = 1'b1;
      end
    join
    waitDrain();

    // Reset with two vectors in flight.
    applyStimulus4({4{32'h3F80_0000}});
    applyStimulus4({32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000});
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("mid reset valid_out", {31'b0, vout4}, 32'd0);
    checkOutput("mid reset out_max", max4, 32'd0);
    checkOutput("mid reset out_idx", {30'b0, idx4}, 32'd0);
    checkOutput("mid reset ready_in", {31'b0, rin4}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      checkOutput("stale after reset", {31'b0, vout4}, 32'd0);
    end
    @(posedge clk);
    #1;

    fork
      begin
        fork
          begin
            for (int n = 0; n < 40; n++) begin
              logic [4*DW-1:0] v;
              for (int k = 0; k < 4; k++) v[DW*k +: DW] = rand_fp();
              if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
              end
              applyStimulus4(v);
            end
          end
          begin
            for (int n = 0; n < 30; n++) begin
              logic [5*DW-1:0] v;
              for (int k = 0; k < 5; k++) v[DW*k +: DW] = rand_fp();
              if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
              end
              applyStimulus5(v);
            end
          end
        join
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          rout4 = ($urandom_range(0, 3) != 0);
          rout5 = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    rout4 = 1'b1;
    rout5 = 1'b1;
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
